ascii_load_sequencer: RTL and testbench

// - Sequences the ACIA receive path between two sources: ioctl ASCII file download (TXT/BAS/LOD) and the UART RXD byte stream.
// - File bytes are buffered in a FIFO and back-pressured via ioctl_wait.
// - Bytes are presented to the ACIA one at a time, with inter-character and end-of-line pacing so that the monitor and BASIC keep up.
// - Sits between hps_io / the UART deserialiser and the uk101 ACIA receive port.

---
 rtl/uk101_pkg.sv | 9 +
 rtl/sync_fifo.sv | 43 ++++
 rtl/ascii_load_sequencer.sv | 111 +++++++++++
 tb/tb_ascii_load_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uk101_pkg.sv
// uk101_pkg: state type, ASCII constants and case mapping shared by the UK101 load path.
package uk101_pkg;
    typedef enum logic [1:0] {LS_IDLE, LS_PRESENT, LS_GAP} load_state_t;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with flush; a push during flush lands in the emptied FIFO.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout = mem[rd];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else if (flush) begin
            rd <= '0;
            wr <= AW'(push);
            count <= (AW+1)'(push);
        end else begin
            rd <= rd + AW'(do_pop);
            wr <= wr + AW'(do_push);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (flush ? push : do_push) mem[flush ? '0 : wr] <= din;
endmodule

// File: rtl/ascii_load_sequencer.sv
// ascii_load_sequencer: feeds the ACIA receive port from a paced ioctl file FIFO or the UART byte stream.
module ascii_load_sequencer
    import uk101_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CHAR_GAP   = 4800,
    parameter int LINE_GAP   = 2400000,
    parameter bit UPCASE     = 1'b1
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       load_from,
    input  logic       ioctl_download,
    input  logic       ioctl_wr,
    input  logic [7:0] ioctl_data,
    output logic       ioctl_wait,
    input  logic       uart_rx_valid,
    input  logic [7:0] uart_rx_data,
    output logic       acia_rx_valid,
    output logic [7:0] acia_rx_data,
    input  logic       acia_rx_ack,
    output logic       uart_overrun,
    output logic       busy
);
    localparam int GW = $clog2(LINE_GAP);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    load_state_t state, state_n;
    logic [GW-1:0] gap, gap_n;
    logic [CW-1:0] count;
    logic [7:0] din, dout, data;
    logic from_q, dl_q, wait_q, hold_valid;
    logic src_chg, dl_rise, flush, push, pop, empty, full;
    assign src_chg = load_from != from_q;
    assign dl_rise = ioctl_download & ~dl_q;
    assign flush = load_from | src_chg | dl_rise;
    assign din = UPCASE ? to_upper(ioctl_data) : ioctl_data;
    assign push = ioctl_wr & ioctl_download & ~load_from & (ioctl_data != ASCII_LF) & (ioctl_data != 8'h00);
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk_sys),
        .rst(reset),
        .push(push),
        .pop(pop),
        .flush(flush),
        .din(din),
        .dout(dout),
        .count(count),
        .empty(empty),
        .full(full)
    );
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= LS_IDLE;
            gap <= '0;
        end else begin
            state <= state_n;
            gap <= gap_n;
        end
    end
    always_comb begin
        state_n = state;
        gap_n = gap;
        pop = 1'b0;
        if (flush) begin
            state_n = LS_IDLE;
            gap_n = '0;
        end else if (state == LS_IDLE) begin
            pop = ~empty;
            state_n = empty ? LS_IDLE : LS_PRESENT;
        end else if (state == LS_PRESENT) begin
            state_n = acia_rx_ack ? LS_GAP : LS_PRESENT;
            gap_n = ~acia_rx_ack ? gap : (data == ASCII_CR) ? GW'(LINE_GAP - 1) : GW'(CHAR_GAP - 1);
        end else begin
            state_n = (gap == '0) ? LS_IDLE : LS_GAP;
            gap_n = (gap == '0) ? gap : gap - 1'b1;
        end
    end
    // Shared output byte register: holds the popped file byte or the latest UART byte.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            data <= '0;
            hold_valid <= 1'b0;
            uart_overrun <= 1'b0;
            from_q <= 1'b0;
            dl_q <= 1'b0;
            wait_q <= 1'b0;
        end else begin
            from_q <= load_from;
            dl_q <= ioctl_download;
            wait_q <= full | (count >= CW'(FIFO_DEPTH - 2));
            if (src_chg) begin
                data <= '0;
                hold_valid <= 1'b0;
                uart_overrun <= 1'b0;
            end else if (load_from) begin
                if (uart_rx_valid) begin
                    data <= uart_rx_data;
                    hold_valid <= 1'b1;
                    if (hold_valid & ~acia_rx_ack) uart_overrun <= 1'b1;
                end else if (acia_rx_ack) begin
                    hold_valid <= 1'b0;
                end
            end else if (pop) begin
                data <= dout;
            end
        end
    end
    assign ioctl_wait = wait_q & ~load_from;
    assign acia_rx_valid = load_from ? hold_valid : (state == LS_PRESENT) & ~dl_rise;
    assign acia_rx_data = data;
    assign busy = ~load_from & (~empty | (state != LS_IDLE));
endmodule

// File: tb/tb_ascii_load_sequencer.sv
// tb_ascii_load_sequencer: table vectors, directed corner sequences and a random file stream
// checked against a queue model of filtering, upcasing, ordering and pacing.
module tb_ascii_load_sequencer;
    localparam int FD = 8;
    localparam int CG = 4;
    localparam int LG = 20;

    logic clk_sys = 1'b0, reset = 1'b1, load_from = 1'b0, ioctl_download = 1'b0, ioctl_wr = 1'b0;
    logic uart_rx_valid = 1'b0, acia_rx_ack = 1'b0;
    logic [7:0] ioctl_data = 8'h00, uart_rx_data = 8'h00;
    logic ioctl_wait, acia_rx_valid, uart_overrun, busy;
    logic [7:0] acia_rx_data;

    int n_checks = 0, n_fail = 0, cyc = 0, written = 0, first_wait = -1;
    logic [7:0] src_q[$], exp_q[$];
    int gaps_q[$];

    typedef struct {
        logic [7:0] din;
        logic       keep;
        logic [7:0] dout;
    } vec_t;
    vec_t vt[12];

    ascii_load_sequencer #(.FIFO_DEPTH(FD), .CHAR_GAP(CG), .LINE_GAP(LG), .UPCASE(1'b1)) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .load_from(load_from),
        .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr),
        .ioctl_data(ioctl_data),
        .ioctl_wait(ioctl_wait),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_data(uart_rx_data),
        .acia_rx_valid(acia_rx_valid),
        .acia_rx_data(acia_rx_data),
        .acia_rx_ack(acia_rx_ack),
        .uart_overrun(uart_overrun),
        .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model_up(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    endfunction

    function automatic bit model_keep(input logic [7:0] b);
        return b != 8'h0A && b != 8'h00;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    task automatic step();
        @(negedge clk_sys);
    endtask

    task automatic file_write(input logic [7:0] b);
        ioctl_wr = 1'b1;
        ioctl_data = b;
        if (model_keep(b)) exp_q.push_back(model_up(b));
        step();
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max && busy; i++) step();
        chk("idle reached", busy, 0);
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (acia_rx_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic take(input string name);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected no byte", name, acia_rx_data);
        end else begin
            e = exp_q.pop_front();
            chk(name, acia_rx_data, e);
        end
    endtask

    task automatic ack_now(input string name);
        take(name);
        acia_rx_ack = 1'b1;
        step();
        acia_rx_ack = 1'b0;
    endtask

    // Concurrent hps_io writer (honours ioctl_wait) and ACIA sink (random acks) against the queue model.
    task automatic run_stream(input int ack_pct, input int wr_pct, input int budget, input bit need_done);
        bit have_ack = 0, prev_v = 0, prev_ack = 0, last_cr = 0, done = 0;
        int last_ack = 0, g;
        logic [7:0] prev_d = 8'h00;
        written = 0;
        first_wait = -1;
        gaps_q.delete();
        for (int i = 0; i < budget; i++) begin
            if (acia_rx_valid && !prev_v && have_ack) begin
                g = cyc - last_ack - 1;
                gaps_q.push_back(g);
                chk_range(last_cr ? "line gap" : "char gap", g, last_cr ? LG + 1 : CG + 1, 1000000);
            end
            if (acia_rx_valid && prev_v && !prev_ack) chk("data held", acia_rx_data, prev_d);
            prev_v = acia_rx_valid;
            prev_d = acia_rx_data;
            prev_ack = 1'b0;
            acia_rx_ack = 1'b0;
            if (acia_rx_valid && $urandom_range(99) < ack_pct) begin
                take("stream data");
                acia_rx_ack = 1'b1;
                prev_ack = 1'b1;
                have_ack = 1'b1;
                last_ack = cyc;
                last_cr = acia_rx_data == 8'h0D;
            end
            if (ioctl_wait && first_wait < 0) first_wait = written;
            ioctl_wr = 1'b0;
            if (src_q.size() != 0 && !ioctl_wait && $urandom_range(99) < wr_pct) begin
                ioctl_data = src_q.pop_front();
                if (model_keep(ioctl_data)) exp_q.push_back(model_up(ioctl_data));
                ioctl_wr = 1'b1;
                written++;
            end
            if (src_q.size() == 0 && exp_q.size() == 0 && !acia_rx_valid && !ioctl_wr && !acia_rx_ack) begin
                done = 1'b1;
                break;
            end
            step();
        end
        acia_rx_ack = 1'b0;
        ioctl_wr = 1'b0;
        if (need_done) begin
            chk("stream completed", done, 1);
            chk("bytes left undelivered", exp_q.size(), 0);
        end
    endtask

    initial begin
        bit ok;
        vt = '{
            '{8'h61, 1'b1, 8'h41}, '{8'h7A, 1'b1, 8'h5A}, '{8'h60, 1'b1, 8'h60}, '{8'h7B, 1'b1, 8'h7B},
            '{8'h41, 1'b1, 8'h41}, '{8'h0A, 1'b0, 8'h00}, '{8'h00, 1'b0, 8'h00}, '{8'h6D, 1'b1, 8'h4D},
            '{8'hE1, 1'b1, 8'hE1}, '{8'h0D, 1'b1, 8'h0D}, '{8'h30, 1'b1, 8'h30}, '{8'h5A, 1'b1, 8'h5A}
        };
        step();
        step();
        chk("reset acia_rx_valid", acia_rx_valid, 0);
        chk("reset acia_rx_data", acia_rx_data, 0);
        chk("reset ioctl_wait", ioctl_wait, 0);
        chk("reset uart_overrun", uart_overrun, 0);
        chk("reset busy", busy, 0);
        reset = 1'b0;
        ioctl_download = 1'b1;
        step();
        step();

        // Byte filter / upcase table
        foreach (vt[i]) begin
            wait_idle(60);
            file_write(vt[i].din);
            if (vt[i].keep) begin
                wait_valid(8, ok);
                chk("vector valid", ok, 1);
                chk("vector data", acia_rx_data, vt[i].dout);
                ack_now("vector model");
            end else begin
                repeat (4) step();
                chk("dropped byte valid", acia_rx_valid, 0);
                chk("dropped byte busy", busy, 0);
            end
        end

        // "A\r\nb": order and pacing after a plain byte and after CR
        wait_idle(60);
        src_q = '{8'h41, 8'h0D, 8'h0A, 8'h62};
        run_stream(100, 100, 200, 1);
        chk("gap count", gaps_q.size(), 2);
        if (gaps_q.size() >= 2) begin
            chk("char gap cycles", gaps_q[0], CG + 1);
            chk("line gap cycles", gaps_q[1], LG + 1);
        end

        // Minimum latency: the cycle after the write the byte is not yet presented
        wait_idle(60);
        file_write(8'h21);
        chk("latency not early", acia_rx_valid, 0);
        step();
        chk("latency two cycles", acia_rx_valid, 1);
        ack_now("latency data");

        // Burst of 12 with no acks, then drain
        wait_idle(60);
        for (int i = 0; i < 12; i++) src_q.push_back(8'h41 + 8'(i));
        run_stream(0, 100, 30, 0);
        chk_range("writes before ioctl_wait", first_wait, FD - 1, FD);
        chk("writes stop under ioctl_wait", written, first_wait);
        chk("ioctl_wait held", ioctl_wait, 1);
        chk("first burst byte presented", acia_rx_valid, 1);
        chk("first burst byte data", acia_rx_data, 8'h41);
        run_stream(100, 100, 600, 1);
        chk("ioctl_wait released", ioctl_wait, 0);

        // Push and pop in the same cycle at count 3, then wrap the pointers
        wait_idle(60);
        for (int i = 0; i < 4; i++) file_write(8'h30 + 8'(i));
        chk("fifo count before ack", int'(dut.u_fifo.count), 3);
        ack_now("wrap first byte");
        repeat (4) step();
        chk("fifo count at pop", int'(dut.u_fifo.count), 3);
        chk("idle before pop", acia_rx_valid, 0);
        file_write(8'h34);
        chk("fifo count after push+pop", int'(dut.u_fifo.count), 3);
        chk("popped byte presented", acia_rx_valid, 1);
        chk("popped byte data", acia_rx_data, 8'h31);
        for (int i = 0; i < 15; i++) src_q.push_back(8'h35 + 8'(i));
        run_stream(100, 100, 600, 1);

        // Download restart during GAP with 5 queued
        wait_idle(60);
        for (int i = 0; i < 6; i++) file_write(8'h61 + 8'(i));
        wait_valid(10, ok);
        chk("restart first valid", ok, 1);
        ack_now("restart first data");
        ioctl_download = 1'b0;
        step();
        ioctl_download = 1'b1;
        #1;
        chk("restart valid during edge", acia_rx_valid, 0);
        step();
        chk("restart busy cleared", busy, 0);
        chk("restart valid cleared", acia_rx_valid, 0);
        exp_q.delete();
        repeat (30) step();
        chk("restart no resume", acia_rx_valid, 0);

        // Download restart during PRESENT clears valid in the same cycle
        file_write(8'h51);
        wait_valid(10, ok);
        chk("present valid", ok, 1);
        ioctl_download = 1'b0;
        step();
        chk("present still valid", acia_rx_valid, 1);
        ioctl_download = 1'b1;
        #1;
        chk("present valid same cycle clear", acia_rx_valid, 0);
        step();
        exp_q.delete();
        chk("present restart busy", busy, 0);

        // Asynchronous reset in PRESENT
        file_write(8'h31);
        wait_valid(10, ok);
        chk("reset test valid", ok, 1);
        #2 reset = 1'b1;
        #1;
        chk("async reset valid", acia_rx_valid, 0);
        chk("async reset data", acia_rx_data, 0);
        chk("async reset busy", busy, 0);
        chk("async reset wait", ioctl_wait, 0);
        chk("async reset overrun", uart_overrun, 0);
        step();
        reset = 1'b0;
        exp_q.delete();
        repeat (10) step();
        chk("post reset no byte", acia_rx_valid, 0);
        file_write(8'h5A);
        wait_valid(10, ok);
        chk("post reset new byte", ok, 1);
        ack_now("post reset data");

        // UART mode
        wait_idle(60);
        load_from = 1'b1;
        step();
        step();
        chk("uart idle valid", acia_rx_valid, 0);
        chk("uart busy", busy, 0);
        chk("uart ioctl_wait", ioctl_wait, 0);
        uart_rx_valid = 1'b1;
        uart_rx_data = 8'h55;
        step();
        chk("uart 55 valid", acia_rx_valid, 1);
        chk("uart 55 data", acia_rx_data, 8'h55);
        chk("uart no overrun", uart_overrun, 0);
        uart_rx_data = 8'hAA;
        step();
        uart_rx_valid = 1'b0;
        chk("uart overwrite data", acia_rx_data, 8'hAA);
        chk("uart overrun set", uart_overrun, 1);
        acia_rx_ack = 1'b1;
        uart_rx_valid = 1'b1;
        uart_rx_data = 8'h33;
        step();
        uart_rx_valid = 1'b0;
        chk("uart ack+strobe valid", acia_rx_valid, 1);
        chk("uart ack+strobe data", acia_rx_data, 8'h33);
        step();
        acia_rx_ack = 1'b0;
        chk("uart ack clears valid", acia_rx_valid, 0);
        chk("uart overrun sticky", uart_overrun, 1);
        acia_rx_ack = 1'b1;
        step();
        acia_rx_ack = 1'b0;
        chk("uart stray ack", acia_rx_valid, 0);
        ioctl_wr = 1'b1;
        ioctl_data = 8'h51;
        step();
        ioctl_wr = 1'b0;
        chk("uart ignores ioctl busy", busy, 0);
        chk("uart ignores ioctl wait", ioctl_wait, 0);
        load_from = 1'b0;
        step();
        chk("mode change clears overrun", uart_overrun, 0);
        chk("mode change valid", acia_rx_valid, 0);
        repeat (5) step();
        chk("uart-mode write not queued", acia_rx_valid, 0);
        chk("file mode idle", busy, 0);

        // Random file streams against the model
        for (int r = 0; r < 2; r++) begin
            wait_idle(60);
            for (int i = 0; i < 80; i++) begin
                case ($urandom_range(9))
                    0: src_q.push_back(8'h0D);
                    1: src_q.push_back(8'h0A);
                    2: src_q.push_back(8'h00);
                    3, 4, 5: src_q.push_back(8'h61 + 8'($urandom_range(25)));
                    default: src_q.push_back(8'($urandom_range(255)));
                endcase
            end
            run_stream(r == 0 ? 60 : 30, r == 0 ? 80 : 40, 6000, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
